// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and twiddle-multiplier state encoding for the FFT stage
package fft_pkg;

   localparam int DATA_W   = 8;
   localparam int TW_W     = 9;
   localparam int PROD_W   = 17;
   localparam int ACC_W    = 18;
   localparam int TW_SHIFT = 8;

   typedef enum logic [2:0] {
      FLUSH = 3'd0,
      IDLE  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4,
      DONE  = 3'd5
   } cmul_state_t;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

endpackage

// File: rtl/cmplx_twiddle_mult_if.sv
// rtl/cmplx_twiddle_mult_if.sv - request/result and serial-multiplier signals of the twiddle multiplier
interface cmplx_twiddle_mult_if;
   import fft_pkg::*;

   logic                     start;
   logic signed [DATA_W-1:0] a_re;
   logic signed [DATA_W-1:0] a_im;
   logic signed [TW_W-1:0]   w_re;
   logic signed [TW_W-1:0]   w_im;
   logic                     busy;
   logic                     data_valid;
   logic signed [DATA_W-1:0] y_re;
   logic signed [DATA_W-1:0] y_im;
   logic                     mul_start;
   logic signed [DATA_W-1:0] mul_in0;
   logic signed [TW_W-1:0]   mul_in1;
   logic                     mul_valid;
   logic signed [PROD_W-1:0] mul_out;

   modport slave (
      input  start, a_re, a_im, w_re, w_im, mul_valid, mul_out,
      output busy, data_valid, y_re, y_im, mul_start, mul_in0, mul_in1
   );

   modport master (
      output start, a_re, a_im, w_re, w_im, mul_valid, mul_out,
      input  busy, data_valid, y_re, y_im, mul_start, mul_in0, mul_in1
   );

endinterface

// File: rtl/cmul_round_sat.sv
// rtl/cmul_round_sat.sv - accumulator scale by >>> 8, optional round half up (CMUL_ROUND_EN), saturate to 8 bits
module cmul_round_sat
   import fft_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] y
);

   localparam int                      SAT_MAX_I = (2 ** (DATA_W - 1)) - 1;
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(SAT_MAX_I);
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-SAT_MAX_I - 1);
   localparam logic signed [ACC_W-1:0] HALF_LSB  = ACC_W'(2 ** (TW_SHIFT - 1));

   logic signed [ACC_W-1:0] biased;
   logic signed [ACC_W-1:0] scaled;

   // |acc| never exceeds 65536, so adding the half LSB cannot wrap 18 bits
   always_comb begin
`ifdef CMUL_ROUND_EN
      biased = acc + HALF_LSB;
`else
      biased = acc;
`endif
      scaled = biased >>> TW_SHIFT;
      if (scaled > SAT_MAX) begin
         y = SAT_MAX[DATA_W-1:0];
      end else if (scaled < SAT_MIN) begin
         y = SAT_MIN[DATA_W-1:0];
      end else begin
         y = scaled[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/cmplx_twiddle_mult.sv
// rtl/cmplx_twiddle_mult.sv - sequences y = a * w through a shared serial real multiplier (4 products)
module cmplx_twiddle_mult
   import fft_pkg::*;
#(
   parameter int MUL_FLUSH = 20
)
(
   input  logic                 clk,
   input  logic                 rst,
   cmplx_twiddle_mult_if.slave  bus
);

   localparam int             FCW        = (MUL_FLUSH > 1) ? $clog2(MUL_FLUSH) : 1;
   localparam logic [FCW-1:0] FLUSH_LAST = FCW'(MUL_FLUSH - 1);

   cmul_state_t              state;
   cmul_state_t              state_nxt;
   logic [FCW-1:0]           flush_cnt;
   logic [1:0]               k;
   logic signed [DATA_W-1:0] a_re_q;
   logic signed [DATA_W-1:0] a_im_q;
   logic signed [TW_W-1:0]   w_re_q;
   logic signed [TW_W-1:0]   w_im_q;
   logic signed [ACC_W-1:0]  acc_re;
   logic signed [ACC_W-1:0]  acc_im;
   logic signed [ACC_W-1:0]  prod_ext;
   logic                     mul_valid_q;
   logic                     mul_edge;
   logic signed [DATA_W-1:0] y_re_q;
   logic signed [DATA_W-1:0] y_im_q;
   logic signed [DATA_W-1:0] y_re_sat;
   logic signed [DATA_W-1:0] y_im_sat;
   logic                     data_valid_q;
   logic                     busy_c;
   logic                     mul_start_c;
   logic signed [DATA_W-1:0] op0;
   logic signed [TW_W-1:0]   op1;

   // only a fresh rising edge is a product; the multiplier may hold valid high
   assign mul_edge = bus.mul_valid & ~mul_valid_q;
   assign prod_ext = sext_prod(bus.mul_out);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FLUSH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy_c      = 1'b1;
      mul_start_c = 1'b0;
      unique case (state)
         FLUSH: begin
            if (flush_cnt == FLUSH_LAST) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mul_start_c = 1'b1;
            state_nxt   = WAIT;
         end
         WAIT: begin
            if (mul_edge) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            state_nxt = (k == 2'd3) ? DONE : ISSUE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = FLUSH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt    <= '0;
         k            <= 2'd0;
         a_re_q       <= '0;
         a_im_q       <= '0;
         w_re_q       <= '0;
         w_im_q       <= '0;
         acc_re       <= '0;
         acc_im       <= '0;
         mul_valid_q  <= 1'b0;
         y_re_q       <= '0;
         y_im_q       <= '0;
         data_valid_q <= 1'b0;
      end else begin
         mul_valid_q  <= bus.mul_valid;
         data_valid_q <= 1'b0;
         unique case (state)
            FLUSH: begin
               if (flush_cnt != FLUSH_LAST) begin
                  flush_cnt <= flush_cnt + FCW'(1);
               end
            end
            IDLE: begin
               if (bus.start) begin
                  a_re_q <= bus.a_re;
                  a_im_q <= bus.a_im;
                  w_re_q <= bus.w_re;
                  w_im_q <= bus.w_im;
                  k      <= 2'd0;
                  acc_re <= '0;
                  acc_im <= '0;
               end
            end
            WAIT: begin
               if (mul_edge) begin
                  unique case (k)
                     2'd0:    acc_re <= acc_re + prod_ext;
                     2'd1:    acc_re <= acc_re - prod_ext;
                     default: acc_im <= acc_im + prod_ext;
                  endcase
               end
            end
            GAP: begin
               if (k != 2'd3) begin
                  k <= k + 2'd1;
               end
            end
            DONE: begin
               y_re_q       <= y_re_sat;
               y_im_q       <= y_im_sat;
               data_valid_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // product order: a_re*w_re, a_im*w_im, a_re*w_im, a_im*w_re
   always_comb begin
      op0 = a_re_q;
      op1 = w_re_q;
      unique case (k)
         2'd0: begin op0 = a_re_q; op1 = w_re_q; end
         2'd1: begin op0 = a_im_q; op1 = w_im_q; end
         2'd2: begin op0 = a_re_q; op1 = w_im_q; end
         default: begin op0 = a_im_q; op1 = w_re_q; end
      endcase
   end

   cmul_round_sat u_sat_re (
      .acc (acc_re),
      .y   (y_re_sat)
   );

   cmul_round_sat u_sat_im (
      .acc (acc_im),
      .y   (y_im_sat)
   );

   assign bus.busy       = busy_c;
   assign bus.mul_start  = mul_start_c;
   assign bus.mul_in0    = op0;
   assign bus.mul_in1    = op1;
   assign bus.data_valid = data_valid_q;
   assign bus.y_re       = y_re_q;
   assign bus.y_im       = y_im_q;

endmodule

// File: tb/tb_cmplx_twiddle_mult.sv
// tb/tb_cmplx_twiddle_mult.sv - randomized bench with serial multiplier model and complex-product reference
module tb_cmplx_twiddle_mult;
   import fft_pkg::*;

   localparam int LAT = 21;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmplx_twiddle_mult_if bus ();

   cmplx_twiddle_mult #(.MUL_FLUSH(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          y_re;
      int          y_im;
      int unsigned due;
   } exp_t;

   exp_t        expq[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          last_re = 0;
   int          last_im = 0;
   logic        ms_s = 1'b0;
   logic        prev_ms = 1'b0;
   logic signed [7:0] in0_s = '0;
   logic signed [8:0] in1_s = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int scale_sat(input int acc);
      int v;
      v = acc;
`ifdef CMUL_ROUND_EN
      v = v + 128;
`endif
      v = v >>> 8;
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         ms_s  = bus.mul_start;
         in0_s = bus.mul_in0;
         in1_s = bus.mul_in1;
      end
   end

   // multiplier: product visible after 2 edges, captured on the 3rd; valid held until next start
   initial begin
      int cnt;
      int prod;
      bit pend;
      bit hold;
      bus.mul_valid = 1'b0;
      bus.mul_out   = '0;
      cnt  = 0;
      prod = 0;
      pend = 0;
      hold = 0;
      forever begin
         @(posedge clk);
         #1;
         if (ms_s) begin
            pend = 1;
            cnt  = 2;
            prod = int'(in0_s) * int'(in1_s);
            hold = ($urandom_range(0, 1) == 1);
            if (!hold) bus.mul_valid = 1'b0;
         end else if (pend) begin
            if (cnt == 2) begin
               bus.mul_valid = 1'b0;
               cnt = 1;
            end else begin
               bus.mul_valid = 1'b1;
               bus.mul_out   = 17'(prod);
               pend = 0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            chk("mul_start_consecutive", int'(bus.mul_start && prev_ms), 0);
            if (bus.data_valid) begin
               if (expq.size() == 0) begin
                  chk("unexpected_data_valid", 1, 0);
               end else begin
                  e = expq.pop_front();
                  chk("dv_cycle", int'(cyc), int'(e.due));
                  chk("y_re", int'(bus.y_re), e.y_re);
                  chk("y_im", int'(bus.y_im), e.y_im);
                  last_re = e.y_re;
                  last_im = e.y_im;
               end
            end else begin
               chk("y_re_hold", int'(bus.y_re), last_re);
               chk("y_im_hold", int'(bus.y_im), last_im);
               if (expq.size() > 0 && cyc > expq[0].due) begin
                  chk("dv_missing", int'(cyc), int'(expq[0].due));
                  void'(expq.pop_front());
               end
            end
         end
         prev_ms = bus.mul_start;
      end
   end

   task automatic issue(input int ar, input int ai, input int wr, input int wi);
      exp_t e;
      chk("idle_before_start", int'(bus.busy), 0);
      bus.a_re  = 8'(ar);
      bus.a_im  = 8'(ai);
      bus.w_re  = 9'(wr);
      bus.w_im  = 9'(wi);
      bus.start = 1'b1;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      e.y_re = scale_sat(ar * wr - ai * wi);
      e.y_im = scale_sat(ar * wi + ai * wr);
      e.due  = cyc + LAT;
      expq.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bus.busy !== 1'b0) chk("busy_timeout", 1, 0);
   endtask

   task automatic do_op(input int ar, input int ai, input int wr, input int wi);
      wait_idle();
      issue(ar, ai, wr, wi);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (expq.size() > 0 && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (expq.size() > 0) begin
         chk("drain_timeout", expq.size(), 0);
         expq.delete();
      end
   endtask

   // assumes rst was sampled on the last edge and is released now
   task automatic flush_check();
      rst = 1'b0;
      chk("rst_y_re", int'(bus.y_re), 0);
      chk("rst_y_im", int'(bus.y_im), 0);
      chk("rst_data_valid", int'(bus.data_valid), 0);
      chk("rst_mul_start", int'(bus.mul_start), 0);
      chk("rst_mul_in0", int'(bus.mul_in0), 0);
      chk("rst_mul_in1", int'(bus.mul_in1), 0);
      chk("rst_busy", int'(bus.busy), 1);
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         #1;
         chk("flush_busy", int'(bus.busy), 1);
         chk("flush_no_dv", int'(bus.data_valid), 0);
      end
      @(negedge clk);
      #1;
      chk("flush_end_busy", int'(bus.busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ar, ai, wr, wi;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a_re  = '0;
      bus.a_im  = '0;
      bus.w_re  = '0;
      bus.w_im  = '0;
      repeat (3) @(negedge clk);
      #1;
      flush_check();

`ifdef CMUL_ROUND_EN
      chk("model_pin_64", scale_sat(64 * 255), 64);
      chk("model_pin_neg", scale_sat(-5100), -20);
      chk("model_pin_pos", scale_sat(2550), 10);
`else
      chk("model_pin_64", scale_sat(64 * 255), 63);
      chk("model_pin_neg", scale_sat(-5100), -20);
      chk("model_pin_pos", scale_sat(2550), 9);
`endif
      chk("model_pin_sat", scale_sat(32768), 127);

      do_op(64, 0, 255, 0);
      wait_drain();
`ifdef CMUL_ROUND_EN
      chk("lit_64_re", int'(bus.y_re), 64);
`else
      chk("lit_64_re", int'(bus.y_re), 63);
`endif
      chk("lit_64_im", int'(bus.y_im), 0);

      do_op(-128, -128, -256, 0);
      wait_drain();
      chk("lit_sat_re", int'(bus.y_re), 127);
      chk("lit_sat_im", int'(bus.y_im), 127);

      do_op(10, 20, 0, 255);
      wait_drain();
      chk("lit_j_re", int'(bus.y_re), -20);
`ifdef CMUL_ROUND_EN
      chk("lit_j_im", int'(bus.y_im), 10);
`else
      chk("lit_j_im", int'(bus.y_im), 9);
`endif

      // start while busy must be ignored; then start right after data_valid
      do_op(30, -40, 100, -200);
      repeat (5) begin
         @(negedge clk);
         #1;
      end
      chk("busy_during_wait", int'(bus.busy), 1);
      bus.a_re  = 8'sd1;
      bus.a_im  = 8'sd1;
      bus.w_re  = 9'sd1;
      bus.w_im  = 9'sd1;
      bus.start = 1'b1;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
      wait_drain();
      @(negedge clk);
      #1;
      issue(-77, 55, -256, 255);
      wait_drain();

      // reset during WAIT of the third product
      do_op(50, -60, 120, -130);
      repeat (12) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b1;
      expq.delete();
      last_re = 0;
      last_im = 0;
      @(negedge clk);
      #1;
      flush_check();
      do_op(-100, 90, 200, -50);
      wait_drain();

      for (int n = 0; n < 40; n++) begin
         ar = int'($urandom_range(0, 255)) - 128;
         ai = int'($urandom_range(0, 255)) - 128;
         wr = int'($urandom_range(0, 511)) - 256;
         wi = int'($urandom_range(0, 511)) - 256;
         if (n % 10 == 0) begin
            ar = -128;
            wr = -256;
         end
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            #1;
         end
         do_op(ar, ai, wr, wi);
      end
      wait_drain();
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
